// File: rtl/mu0_pc_pkg.sv
// MU0 program-counter shared definitions.
// Op encodings used by mu0_pc_unit and its bench.
package mu0_pc_pkg;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;

endpackage

// File: rtl/mu0_pc_stack.sv
// MU0 return-address LIFO: DEPTH x WIDTH entries, sync-reset count.
// Ports: Clk, Reset, push, pop, data_in -> top, count, empty, full.
module mu0_pc_stack #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    cnt_m1;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;

   assign cnt_m1 = count - CW'(1);
   assign wr_idx = count[AW-1:0];
   assign rd_idx = cnt_m1[AW-1:0];

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   // Top is read from count-1; garbage when empty, caller ignores it.
   assign top   = mem[rd_idx];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= cnt_m1;
      end
   end

   // Entry contents need no reset; only count defines validity.
   always_ff @(posedge Clk) begin
      if (!Reset && push && !full) begin
         mem[wr_idx] <= data_in;
      end
   end

endmodule

// File: rtl/mu0_pc_unit.sv
// MU0 PC: hold/inc/load/call/ret, Wrap/Err pulses, optional LIFO.
// Ports: Clk, Reset, En, Op, D -> Q, Wrap, Err, StkEmpty, StkFull.
// Macro MU0_PC_STACK_EN builds the return stack.
module mu0_pc_unit
   import mu0_pc_pkg::*;
#(
   parameter int WIDTH       = 12,
   parameter int STEP        = 1,
   parameter int RESET_VAL   = 0,
   parameter int STACK_DEPTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Wrap,
   output logic             Err,
   output logic             StkEmpty,
   output logic             StkFull
);

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             err_nxt;

`ifdef MU0_PC_STACK_EN
   localparam int CW = $clog2(STACK_DEPTH + 1);

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] ret_addr;
   logic [WIDTH-1:0] stk_top;
   logic [CW-1:0]    stk_cnt;

   assign ret_addr = Q + WIDTH'(STEP);

   mu0_pc_stack #(
      .WIDTH (WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .Clk     (Clk),
      .Reset   (Reset),
      .push    (push),
      .pop     (pop),
      .data_in (ret_addr),
      .top     (stk_top),
      .count   (stk_cnt),
      .empty   (StkEmpty),
      .full    (StkFull)
   );
`else
   assign StkEmpty = 1'b1;
   assign StkFull  = 1'b0;
`endif

   always_comb begin
      q_nxt    = Q;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
`ifdef MU0_PC_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
`endif
      if (En) begin
         unique case (1'b1)
            (Op == OP_INC): begin
               {wrap_nxt, q_nxt} = {1'b0, Q} + (WIDTH + 1)'(STEP);
            end
            (Op == OP_LOAD): begin
               q_nxt = D;
            end
            (Op == OP_CALL): begin
`ifdef MU0_PC_STACK_EN
               if (!StkFull) begin
                  push  = 1'b1;
                  q_nxt = D;
               end else begin
                  err_nxt = 1'b1;
               end
`else
               q_nxt   = D;
               err_nxt = 1'b1;
`endif
            end
            (Op == OP_RET): begin
`ifdef MU0_PC_STACK_EN
               if (!StkEmpty) begin
                  pop   = 1'b1;
                  q_nxt = stk_top;
               end else begin
                  err_nxt = 1'b1;
               end
`else
               err_nxt = 1'b1;
`endif
            end
            default: begin
               q_nxt = Q;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Q    <= WIDTH'(RESET_VAL);
         Wrap <= 1'b0;
         Err  <= 1'b0;
      end else begin
         Q    <= q_nxt;
         Wrap <= wrap_nxt;
         Err  <= err_nxt;
      end
   end

endmodule
